// File: rtl/ram_arbiter_if.sv
// RAM state encoding shared with the CPU, plus the requester/RAM bundle
// between the arbiter (slave) and the requesters and RAM model (master).
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface ram_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]       req_ren;
  logic [NREQ-1:0]       req_wen;
  logic [NREQ-1:0][31:0] req_addr;
  logic [NREQ-1:0][31:0] req_store;
  logic [NREQ-1:0]       req_wait;
  logic [NREQ-1:0]       req_err;
  logic [31:0]           req_load;

  logic                     ramREN;
  logic                     ramWEN;
  logic [31:0]              ramaddr;
  logic [31:0]              ramstore;
  cpu_types_pkg::ramstate_t ramstate;
  logic [31:0]              ramload;

  modport slave (
    input  req_ren, req_wen, req_addr, req_store, ramstate, ramload,
    output req_wait, req_err, req_load, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output req_ren, req_wen, req_addr, req_store, ramstate, ramload,
    input  req_wait, req_err, req_load, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving NREQ requesters shared access to one RAM port;
// writers outrank readers, and a stuck RAM is released after TIMEOUT cycles.
module ram_arbiter #(
  parameter int         NREQ    = 4,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic CLK,
  input  logic RST,
  ram_arbiter_if.slave bus,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant,
  output logic busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_q;
  logic [7:0]      count_q;

  logic [GW-1:0]   sel_d;
  logic [GW-1:0]   rr_d;
  logic [NREQ-1:0] active;
  logic [NREQ-1:0] level;
  logic            found;
  int              idx;
  logic            grant_active;
  logic            serving;
  logic            done_ok;
  logic            fail;

  // Writers take the whole level when present; scan from rr_q with wrap.
  always_comb begin
    active = bus.req_ren | bus.req_wen;
    level  = (|bus.req_wen) ? bus.req_wen : bus.req_ren;
    sel_d  = rr_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && level[idx]) begin
        found = 1'b1;
        sel_d = GW'(idx);
      end
    end
  end

  always_comb begin
    grant_active = active[grant_q];
    serving      = (state_q == S_BUSY) && grant_active;
    done_ok      = serving && (bus.ramstate == cpu_types_pkg::ACCESS);
    // The timeout fires on the TIMEOUT-th BUSY cycle; ACCESS in that cycle still wins.
    fail         = serving && !done_ok &&
                   ((bus.ramstate == cpu_types_pkg::ERROR) ||
                    (count_q == TIMEOUT - 8'd1));
    rr_d         = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.req_wait = '1;
    bus.req_err  = '0;
    bus.req_load = bus.ramload;
    if (serving) begin
      bus.ramWEN   = bus.req_wen[grant_q];
      bus.ramREN   = bus.req_ren[grant_q] & ~bus.req_wen[grant_q];
      bus.ramaddr  = bus.req_addr[grant_q];
      bus.ramstore = bus.req_store[grant_q];
    end
    if (done_ok) bus.req_wait[grant_q] = 1'b0;
    if (fail)    bus.req_err[grant_q]  = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_q <= '0;
          if (|active) begin
            grant_q <= sel_d;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          count_q <= count_q + 8'd1;
          if (!grant_active) begin
            state_q <= S_IDLE;
            count_q <= '0;
          end else if (done_ok || fail) begin
            state_q <= S_IDLE;
            rr_q    <= rr_d;
            count_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == S_BUSY);

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (index 0..NREQ-1).
REQ-002 SHALL have parameter TIMEOUT, default 255, max BUSY cycles before forced release (8-bit).
REQ-003 SHALL have port CLK, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port req_ren, input, NREQ, per-requester read request.
REQ-006 SHALL have port req_wen, input, NREQ, per-requester write request.
REQ-007 SHALL have port req_addr, input, NREQ x 32, per-requester word address.
REQ-008 SHALL have port req_store, input, NREQ x 32, per-requester write data.
REQ-009 SHALL have port req_wait, output, NREQ, per-requester wait; 0 only in its completing cycle.
REQ-010 SHALL have port req_err, output, NREQ, per-requester one-cycle error/timeout pulse.
REQ-011 SHALL have port req_load, output, 32, read data broadcast to all requesters (= ramload).
REQ-012 SHALL have ports ramREN, ramWEN, output, 1 each, RAM strobes.
REQ-013 SHALL have ports ramaddr, ramstore, output, 32 each, RAM address and write data.
REQ-014 SHALL have port ramstate, input, 2, ramstate_t from cpu_types_pkg (FREE, BUSY, ACCESS, ERROR).
REQ-015 SHALL have port ramload, input, 32, RAM read data.
REQ-016 SHALL have port grant, output, clog2(NREQ), index of current owner (valid in BUSY).
REQ-017 SHALL have port busy, output, 1, high when state is BUSY.

Function
REQ-018 SHALL implement states IDLE and BUSY; request active(i) = req_ren[i] | req_wen[i].
REQ-019 In IDLE with any request active, SHALL latch grant and go to BUSY next cycle; no RAM strobe in IDLE.
REQ-020 Selection SHALL be two-level: if any req_wen set, choose among writers only, else among readers.
REQ-021 Within a level, SHALL pick the first active index at or after rr_ptr, wrapping NREQ-1 -> 0.
REQ-022 In BUSY, ramWEN = req_wen[grant]; ramREN = req_ren[grant] & ~req_wen[grant]; ramaddr/ramstore driven combinationally from grant's inputs; else all RAM outputs 0.
REQ-023 In BUSY with ramstate == ACCESS, SHALL drive req_wait[grant]=0 that cycle, set rr_ptr = grant+1 (mod NREQ), return to IDLE.
REQ-024 In BUSY with ramstate == ERROR, SHALL pulse req_err[grant], keep req_wait[grant]=1, set rr_ptr = grant+1, return to IDLE.
REQ-025 SHALL count BUSY cycles from 0; if count reaches TIMEOUT without ACCESS, pulse req_err[grant], advance rr_ptr, return to IDLE.
REQ-026 If active(grant) drops in BUSY, SHALL return to IDLE next cycle, RAM strobes 0 that cycle, rr_ptr unchanged, no err.
REQ-027 Non-granted requesters SHALL see req_wait=1 at all times; only one req_wait bit may be 0 per cycle.
REQ-028 Minimum transaction latency SHALL be 2 cycles (IDLE grant cycle + one BUSY ACCESS cycle); back-to-back grants insert one IDLE cycle.
REQ-029 Requester changing req_addr/req_store while waiting is unsupported; arbiter SHALL pass values through unlatched.
REQ-030 req_load SHALL equal ramload every cycle regardless of state.

Reset
REQ-031 On RST high at a clock edge, SHALL enter IDLE, rr_ptr=0, counter=0, grant=0; mid-transaction grant is dropped with no ACCESS/err reported.
REQ-032 While in reset/IDLE, outputs SHALL be ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, req_wait=all 1, req_err=0, busy=0.

Verification
REQ-033 Reads from 0 and 2 simultaneously, rr_ptr=0, ramstate ACCESS on 1st BUSY cycle -> grant 0 served cycle 2, req_wait[0]=0; grant 2 served cycle 4.
REQ-034 Read 1 and write 3 simultaneously -> write 3 granted first (ramWEN=1, ramaddr=req_addr[3]); read 1 follows.
REQ-035 All 4 read continuously, ACCESS each BUSY cycle -> grants 0,1,2,3,0 in order; no requester waits more than 4 transactions.
REQ-036 ramstate held BUSY for 255 cycles -> req_err[grant] pulses once, busy drops, next requester granted.
REQ-037 ramstate ERROR on granted write to 0x0000_0040 -> req_err pulse, req_wait stays 1, rr_ptr advances.
REQ-038 RST asserted during BUSY -> next cycle IDLE, all RAM strobes 0, req_wait all 1, rr_ptr=0.
